mem_module_param: RTL and testbench

- Parametrised successor of the SCC instruction/data memory: one word-organised RAM array shared by a read-only instruction port and a read/write data port.
- Adds byte-enable writes, a configurable wait-state counter with a ready/valid handshake on the data port, and address/alignment error reporting.
- Sits beside the single-cycle core; the core fetches through the i-port and performs loads and stores through the d-port.

---
 rtl/mem_module_param.sv | 217 +++++++++++++++++++++
 tb/tb_mem_module_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_module_param.sv
// mem_module_param
// Word-organised RAM shared by a read-only instruction port and a
// read/write data port with byte enables, a configurable wait-state
// counter, a ready/valid handshake and address/alignment fault reporting.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   i_mem_en, i_mem_a        instruction fetch enable and byte address
//   i_mem_v, i_mem_err       registered fetch word and fault flag
//   d_mem_a                  data byte address
//   d_mem_read, d_mem_write  data request (exactly one set = accepted)
//   d_mem_be, d_mem_in_v     write byte enables and write data
//   d_mem_out_v              read data (holds across writes)
//   d_mem_ready              data port idle and able to accept
//   d_mem_valid, d_mem_err   completion pulse and its fault qualifier
module mem_module_param #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int D_WAIT      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_mem_en,
    input  logic [ADDR_WIDTH-1:0]     i_mem_a,
    output logic [DATA_WIDTH-1:0]     i_mem_v,
    output logic                      i_mem_err,
    input  logic [ADDR_WIDTH-1:0]     d_mem_a,
    input  logic                      d_mem_read,
    input  logic                      d_mem_write,
    input  logic [DATA_WIDTH/8-1:0]   d_mem_be,
    input  logic [DATA_WIDTH-1:0]     d_mem_in_v,
    output logic [DATA_WIDTH-1:0]     d_mem_out_v,
    output logic                      d_mem_ready,
    output logic                      d_mem_valid,
    output logic                      d_mem_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH_WORDS);
    localparam logic                  NO_WAIT     = (D_WAIT == 0);
    localparam logic [3:0]            WAIT_INIT   = (D_WAIT > 0) ? 4'(D_WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned or beyond the last word; addresses never wrap or alias.
    function automatic logic addr_fault(input logic [ADDR_WIDTH-1:0] a);
        addr_fault = ((a & ALIGN_MASK) != '0) || ((a >> OFF) >= DEPTH_LIMIT);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        word_idx = IW'(a >> OFF);
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

    state_t                state_r, state_next_s;
    logic [3:0]            cnt_r, cnt_next_s;
    logic [ADDR_WIDTH-1:0] lat_a_r;
    logic [BYTES-1:0]      lat_be_r;
    logic [DATA_WIDTH-1:0] lat_wd_r;
    logic                  lat_wr_r;

    logic                  req_one_s, req_both_s, complete_s;
    logic [ADDR_WIDTH-1:0] acc_a_s;
    logic [BYTES-1:0]      acc_be_s;
    logic [DATA_WIDTH-1:0] acc_wd_s;
    logic                  acc_wr_s, acc_rej_s, acc_fault_s, commit_s;
    logic                  valid_next_s, ready_next_s, err_next_s;
    logic [DATA_WIDTH-1:0] out_next_s;

    assign req_one_s  = d_mem_read ^ d_mem_write;
    assign req_both_s = d_mem_read & d_mem_write;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; complete_s marks the edge on which the access takes effect.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        complete_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_both_s) begin
                    state_next_s = ST_RESP;
                    complete_s   = 1'b1;
                end else if (req_one_s) begin
                    if (NO_WAIT) begin
                        state_next_s = ST_RESP;
                        complete_s   = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = WAIT_INIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                    complete_s   = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Capture the request operands on acceptance for use after the wait states.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_a_r  <= '0;
            lat_be_r <= '0;
            lat_wd_r <= '0;
            lat_wr_r <= 1'b0;
        end else if (state_r == ST_IDLE && req_one_s) begin
            lat_a_r  <= d_mem_a;
            lat_be_r <= d_mem_be;
            lat_wd_r <= d_mem_in_v;
            lat_wr_r <= d_mem_write;
        end
    end

    // Operands of the completing access: live inputs when completing from IDLE.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_a_s  = d_mem_a;
            acc_be_s = d_mem_be;
            acc_wd_s = d_mem_in_v;
            acc_wr_s = d_mem_write;
            acc_rej_s = req_both_s;
        end else begin
            acc_a_s  = lat_a_r;
            acc_be_s = lat_be_r;
            acc_wd_s = lat_wd_r;
            acc_wr_s = lat_wr_r;
            acc_rej_s = 1'b0;
        end
        acc_fault_s = acc_rej_s || addr_fault(acc_a_s);
        commit_s    = complete_s && acc_wr_s && !acc_fault_s;
    end

    // Output next-values; outputs are registered together with the RESP entry.
    always_comb begin
        valid_next_s = complete_s;
        ready_next_s = (state_next_s == ST_IDLE);
        err_next_s   = complete_s && acc_fault_s;
        out_next_s   = d_mem_out_v;
        if (complete_s && !acc_wr_s && !acc_rej_s) begin
            out_next_s = acc_fault_s ? '0 : mem_r[word_idx(acc_a_s)];
        end else begin
            out_next_s = d_mem_out_v;
        end
    end

    // Data-port output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_mem_valid <= 1'b0;
            d_mem_ready <= 1'b1;
            d_mem_err   <= 1'b0;
            d_mem_out_v <= '0;
        end else begin
            d_mem_valid <= valid_next_s;
            d_mem_ready <= ready_next_s;
            d_mem_err   <= err_next_s;
            d_mem_out_v <= out_next_s;
        end
    end

    // Array byte writes; reset suppresses a pending commit, contents are kept.
    always_ff @(posedge clk) begin
        if (rst && commit_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (acc_be_s[b]) begin
                    mem_r[word_idx(acc_a_s)][b*8 +: 8] <= acc_wd_s[b*8 +: 8];
                end
            end
        end
    end

    // Instruction fetch; reads the pre-write word when colliding with a commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_mem_v   <= '0;
            i_mem_err <= 1'b0;
        end else if (i_mem_en) begin
            if (addr_fault(i_mem_a)) begin
                i_mem_v   <= '0;
                i_mem_err <= 1'b1;
            end else begin
                i_mem_v   <= mem_r[word_idx(i_mem_a)];
                i_mem_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_module_param.sv
module tb_mem_module_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [31:0] i_a;
    logic [31:0] d_a;
    logic [3:0]  d_be;
    logic [31:0] d_wd;
    logic        rd_s [3];
    logic        wr_s [3];
    logic [31:0] dout_s [3];
    logic [31:0] iv_s [3];
    logic        ready_s [3];
    logic        valid_s [3];
    logic        err_s [3];
    logic        ierr_s [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_module_param #(.D_WAIT(0)) u0 (
        .clk(clk), .rst(rst), .i_mem_en(i_en), .i_mem_a(i_a),
        .i_mem_v(iv_s[0]), .i_mem_err(ierr_s[0]), .d_mem_a(d_a),
        .d_mem_read(rd_s[0]), .d_mem_write(wr_s[0]), .d_mem_be(d_be),
        .d_mem_in_v(d_wd), .d_mem_out_v(dout_s[0]), .d_mem_ready(ready_s[0]),
        .d_mem_valid(valid_s[0]), .d_mem_err(err_s[0])
    );

    mem_module_param #(.D_WAIT(3)) u3 (
        .clk(clk), .rst(rst), .i_mem_en(i_en), .i_mem_a(i_a),
        .i_mem_v(iv_s[1]), .i_mem_err(ierr_s[1]), .d_mem_a(d_a),
        .d_mem_read(rd_s[1]), .d_mem_write(wr_s[1]), .d_mem_be(d_be),
        .d_mem_in_v(d_wd), .d_mem_out_v(dout_s[1]), .d_mem_ready(ready_s[1]),
        .d_mem_valid(valid_s[1]), .d_mem_err(err_s[1])
    );

    mem_module_param #(.D_WAIT(5)) u5 (
        .clk(clk), .rst(rst), .i_mem_en(i_en), .i_mem_a(i_a),
        .i_mem_v(iv_s[2]), .i_mem_err(ierr_s[2]), .d_mem_a(d_a),
        .d_mem_read(rd_s[2]), .d_mem_write(wr_s[2]), .d_mem_be(d_be),
        .d_mem_in_v(d_wd), .d_mem_out_v(dout_s[2]), .d_mem_ready(ready_s[2]),
        .d_mem_valid(valid_s[2]), .d_mem_err(err_s[2])
    );

    // One data access on instance k; lat counts cycles from accept edge to valid.
    task automatic d_op(input int k, input logic r, input logic w,
                        input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        output int lat, output logic seen,
                        output logic [31:0] dout, output logic err);
        @(negedge clk);
        d_a = a; d_be = be; d_wd = wd; rd_s[k] = r; wr_s[k] = w;
        @(negedge clk);
        rd_s[k] = 1'b0; wr_s[k] = 1'b0;
        lat = 1;
        while (valid_s[k] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        seen = (valid_s[k] === 1'b1);
        dout = dout_s[k];
        err  = err_s[k];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({ready_s[k], valid_s[k], err_s[k], dout_s[k], iv_s[k], ierr_s[k]} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state inst %0d: rdy=%b vld=%b err=%b out=%h iv=%h ierr=%b required rdy=1 others 0",
                         k, ready_s[k], valid_s[k], err_s[k], dout_s[k], iv_s[k], ierr_s[k]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic seen; logic [31:0] dout; logic err;
        d_op(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, seen, dout, err);
        n_checks++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL write_latency: got %0d required 1", lat);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL write_err: got %b required 0", err);
        end
        @(negedge clk);
        n_checks++;
        if ({valid_s[0], ready_s[0]} !== 2'b01) begin
            n_fail++; $display("FAIL valid_one_cycle: valid,ready=%b%b required 01", valid_s[0], ready_s[0]);
        end
        d_op(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, seen, dout, err);
        n_checks++;
        if ({dout, err} !== {32'hDEADBEEF, 1'b0}) begin
            n_fail++; $display("FAIL read_back: got %h err=%b required deadbeef err=0", dout, err);
        end
    endtask

    task automatic test_byte_enable();
        int lat; logic seen; logic [31:0] dout; logic err;
        d_op(0, 1'b0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, lat, seen, dout, err);
        d_op(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, seen, dout, err);
        n_checks++;
        if (dout !== 32'hDEADBEAA) begin
            n_fail++; $display("FAIL byte_enable: got %h required deadbeaa", dout);
        end
        d_op(0, 1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, lat, seen, dout, err);
        n_checks++;
        if ({seen, err} !== 2'b10) begin
            n_fail++; $display("FAIL be_zero_complete: seen=%b err=%b required 1 0", seen, err);
        end
        d_op(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, seen, dout, err);
        n_checks++;
        if (dout !== 32'hDEADBEAA) begin
            n_fail++; $display("FAIL be_zero_unchanged: got %h required deadbeaa", dout);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic seen; logic [31:0] dout; logic err;
        @(negedge clk);
        d_a = 32'h10; rd_s[1] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rd_s[1] = 1'b0;
            n_checks++;
            if ({ready_s[1], valid_s[1]} !== {(k == 5), (k == 4)}) begin
                n_fail++;
                $display("FAIL wait3_edge_N+%0d: ready,valid=%b%b required %b%b",
                         k, ready_s[1], valid_s[1], (k == 5), (k == 4));
            end
        end
        d_op(1, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, lat, seen, dout, err);
        n_checks++;
        if (lat !== 4) begin
            n_fail++; $display("FAIL wait3_latency: got %0d required 4", lat);
        end
    endtask

    task automatic test_faults();
        int lat; logic seen; logic [31:0] dout; logic err;
        for (int i = 0; i < 1024; i++) begin
            d_op(0, 1'b0, 1'b1, 32'(i * 4), 4'hF, 32'h5A000000 | 32'(i), lat, seen, dout, err);
        end
        d_op(0, 1'b1, 1'b0, 32'h13, 4'h0, 32'h0, lat, seen, dout, err);
        n_checks++;
        if ({seen, err, dout} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL misaligned_read: seen=%b err=%b out=%h required 1 1 0", seen, err, dout);
        end
        d_op(0, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, lat, seen, dout, err);
        n_checks++;
        if ({seen, err} !== 2'b11) begin
            n_fail++; $display("FAIL range_read: seen=%b err=%b required 1 1", seen, err);
        end
        d_op(0, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, lat, seen, dout, err);
        n_checks++;
        if ({seen, err} !== 2'b11) begin
            n_fail++; $display("FAIL range_write: seen=%b err=%b required 1 1", seen, err);
        end
        d_op(0, 1'b0, 1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, lat, seen, dout, err);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL misaligned_write: err=%b required 1", err);
        end
        d_op(0, 1'b1, 1'b1, 32'h8, 4'hF, 32'hFFFFFFFF, lat, seen, dout, err);
        n_checks++;
        if ({seen, err} !== 2'b11) begin
            n_fail++; $display("FAIL both_req_reject: seen=%b err=%b required 1 1", seen, err);
        end
        for (int i = 0; i < 1024; i++) begin
            d_op(0, 1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, lat, seen, dout, err);
            n_checks++;
            if ({dout, err} !== {32'h5A000000 | 32'(i), 1'b0}) begin
                n_fail++; $display("FAIL array_intact word %0d: got %h err=%b required %h err=0",
                                   i, dout, err, 32'h5A000000 | 32'(i));
            end
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        d_a = 32'h20; d_be = 4'hF; d_wd = 32'h11111111; wr_s[0] = 1'b1;
        i_en = 1'b1; i_a = 32'h20;
        @(negedge clk);
        wr_s[0] = 1'b0;
        n_checks++;
        if (iv_s[0] !== 32'h5A000008) begin
            n_fail++; $display("FAIL fetch_read_first: got %h required 5a000008", iv_s[0]);
        end
        @(negedge clk);
        n_checks++;
        if (iv_s[0] !== 32'h11111111) begin
            n_fail++; $display("FAIL fetch_after_write: got %h required 11111111", iv_s[0]);
        end
        i_a = 32'h22;
        @(negedge clk);
        n_checks++;
        if ({iv_s[0], ierr_s[0]} !== {32'h0, 1'b1}) begin
            n_fail++; $display("FAIL fetch_misaligned: iv=%h err=%b required 0 1", iv_s[0], ierr_s[0]);
        end
        i_en = 1'b0; i_a = 32'h4;
        @(negedge clk);
        n_checks++;
        if ({iv_s[0], ierr_s[0]} !== {32'h0, 1'b1}) begin
            n_fail++; $display("FAIL fetch_hold: iv=%h err=%b required 0 1", iv_s[0], ierr_s[0]);
        end
        i_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({iv_s[0], ierr_s[0]} !== {32'h5A000001, 1'b0}) begin
            n_fail++; $display("FAIL fetch_word1: iv=%h err=%b required 5a000001 0", iv_s[0], ierr_s[0]);
        end
        i_a = 32'h1000;
        @(negedge clk);
        n_checks++;
        if (ierr_s[0] !== 1'b1) begin
            n_fail++; $display("FAIL fetch_range: err=%b required 1", ierr_s[0]);
        end
        i_en = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int lat; logic seen; logic [31:0] dout; logic err;
        logic saw_valid;
        d_op(2, 1'b0, 1'b1, 32'h40, 4'hF, 32'h77777777, lat, seen, dout, err);
        n_checks++;
        if (lat !== 6) begin
            n_fail++; $display("FAIL wait5_latency: got %0d required 6", lat);
        end
        @(negedge clk);
        d_a = 32'h40; d_be = 4'hF; d_wd = 32'h12345678; wr_s[2] = 1'b1;
        @(negedge clk);
        wr_s[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ready_s[2], valid_s[2]} !== 2'b10) begin
            n_fail++; $display("FAIL mid_reset_state: ready,valid=%b%b required 10", ready_s[2], valid_s[2]);
        end
        rst = 1'b1;
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (valid_s[2] === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_no_valid: saw valid=%b required 0", saw_valid);
        end
        d_op(2, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, lat, seen, dout, err);
        n_checks++;
        if ({dout, err} !== {32'h77777777, 1'b0}) begin
            n_fail++; $display("FAIL mid_reset_word_kept: got %h err=%b required 77777777 0", dout, err);
        end
    endtask

    initial begin
        rst = 1'b0; i_en = 1'b0; i_a = 32'h0; d_a = 32'h0; d_be = 4'h0; d_wd = 32'h0;
        for (int k = 0; k < 3; k++) begin
            rd_s[k] = 1'b0;
            wr_s[k] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_byte_enable();
        test_wait_states();
        test_faults();
        test_collision();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
